// File: rtl/seg_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_pkg
//  Description : Shared constants for the scanned seven-segment driver:
//                the hex->segment table, segment bit positions and the
//                slot-state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_display_pkg;

    // Segment bit positions inside the 8-bit {dp,g,f,e,d,c,b,a} word
    localparam int c_SEG_A  = 0;
    localparam int c_SEG_G  = 6;
    localparam int c_SEG_DP = 7;

    // Per-slot state: blanked guard interval, then the digit is driven
    localparam logic [0:0] c_SLOT_GUARD = 1'b0;
    localparam logic [0:0] c_SLOT_DRIVE = 1'b1;

    // Active-high a..g patterns, index = nibble value (entry F listed first)
    localparam logic [15:0][6:0] c_HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E D C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // B A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage
`default_nettype wire

// File: rtl/seg_hex_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg_hex_decoder
//  Description : Combinational nibble -> active-high a..g segment pattern.
//  Ports       : i_nibble  in   4   hex digit value
//                o_segs    out  7   {g,f,e,d,c,b,a}, 1 = segment lit
//  Revision    : 1.0  initial release
// ============================================================================
module seg_hex_decoder
    import seg_display_pkg::*;
(
    input  logic [3:0]             i_nibble,
    output logic [c_SEG_G:c_SEG_A] o_segs
);

    assign o_segs = c_HEX_SEG[i_nibble];

endmodule
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_display
//  Description : Time-multiplexed N-digit seven-segment driver. Captures a
//                value into a shadow register, scans the digits with an
//                internal refresh prescaler and a blank guard at the start of
//                every slot, and moves the shadow into the displayed copy only
//                when the scan wraps back to digit 0.
//  Option      : define SEG_LEADING_ZERO_BLANK_EN to blank leading zero
//                digits (digit 0 is always shown, decimal points unaffected).
//  Ports       : clock       in   1           rising-edge clock
//                reset       in   1           asynchronous, active-low
//                load        in   1           capture data_in/dp_in
//                data_in     in   DATA_W      value to display
//                dp_in       in   NUM_DIGITS  decimal points, bit k -> digit k
//                blank       in   1           force all outputs inactive
//                seg_out     out  8           {dp,g..a}, polarity ACTIVE_LOW
//                digit_en    out  NUM_DIGITS  one-hot digit select
//                frame_tick  out  1           pulse when scan wraps to digit 0
//                shown_q     out  DATA_W      value currently displayed
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan_display
    import seg_display_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD_CYC   = 8,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic                  blank,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_tick,
    output logic [DATA_W-1:0]     shown_q
);

    localparam int c_PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_PRE_W-1:0]    c_PRE_LAST  = c_PRE_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST  = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic                  c_INV       = (ACTIVE_LOW != 0);
    localparam logic [7:0]            c_SEG_OFF   = {8{c_INV}};
    localparam logic [NUM_DIGITS-1:0] c_DIG_OFF   = {NUM_DIGITS{c_INV}};
    // Prescaler restarts at 0, so the first slot opens in guard when enabled
    localparam logic [0:0]            c_STATE_RST = (GUARD_CYC > 0) ? c_SLOT_GUARD
                                                                    : c_SLOT_DRIVE;

    logic [c_PRE_W-1:0]    r_presc;
    logic [c_IDX_W-1:0]    r_idx;
    logic [0:0]            r_state;
    logic                  r_frame_tick;
    logic                  r_pending;
    logic [DATA_W-1:0]     r_shadow_data;
    logic [NUM_DIGITS-1:0] r_shadow_dp;
    logic [DATA_W-1:0]     r_disp_data;
    logic [NUM_DIGITS-1:0] r_disp_dp;
    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_digit;

    logic                  w_slot_end;
    logic                  w_wrap;
    logic [c_PRE_W-1:0]    w_next_presc;
    logic                  w_next_guard;
    logic [3:0]            w_nibbles [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_show;
    logic [c_SEG_G:c_SEG_A] w_pattern;
    logic [7:0]            w_seg_act;
    logic [NUM_DIGITS-1:0] w_onehot;

    assign w_slot_end   = (r_presc == c_PRE_LAST);
    assign w_wrap       = w_slot_end && (r_idx == c_IDX_LAST);
    assign w_next_presc = w_slot_end ? '0 : r_presc + c_PRE_W'(1);

    // The state register tracks the prescaler value it is about to hold,
    // so state and prescaler always describe the same cycle.
    generate
        if (GUARD_CYC > 0) begin : g_guard
            assign w_next_guard = (w_next_presc < c_PRE_W'(GUARD_CYC));
        end else begin : g_no_guard
            assign w_next_guard = 1'b0;
        end
    endgenerate

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_nib
            assign w_nibbles[k] = r_disp_data[4*k +: 4];
        end
    endgenerate

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Digit k is lit when it or any more significant digit is non-zero;
    // derived from the displayed copy so it never tracks a pending load.
    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
            if (k == 0) begin : g_first
                assign w_show[k] = 1'b1;
            end else begin : g_upper
                assign w_show[k] = (r_disp_data[4*NUM_DIGITS-1 : 4*k] != '0);
            end
        end
    endgenerate
`else
    assign w_show = '1;
`endif

    seg_hex_decoder u_hex_decoder (
        .i_nibble (w_nibbles[r_idx]),
        .o_segs   (w_pattern)
    );

    always_comb begin
        w_seg_act                  = '0;
        w_seg_act[c_SEG_G:c_SEG_A] = w_show[r_idx] ? w_pattern : '0;
        w_seg_act[c_SEG_DP]        = r_disp_dp[r_idx];
    end

    assign w_onehot = NUM_DIGITS'(1) << r_idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_state       <= c_STATE_RST;
            r_frame_tick  <= 1'b0;
            r_pending     <= 1'b0;
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
            r_disp_data   <= '0;
            r_disp_dp     <= '0;
            r_seg         <= c_SEG_OFF;
            r_digit       <= c_DIG_OFF;
        end else begin
            r_presc      <= w_next_presc;
            r_state      <= w_next_guard ? c_SLOT_GUARD : c_SLOT_DRIVE;
            r_frame_tick <= w_wrap;

            if (w_slot_end) begin
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
            end

            if (load) begin
                r_shadow_data <= data_in;
                r_shadow_dp   <= dp_in;
            end

            // A load coinciding with the wrap lands in the shadow only; the
            // display takes the earlier shadow and the new one stays pending.
            if (w_wrap) begin
                if (r_pending) begin
                    r_disp_data <= r_shadow_data;
                    r_disp_dp   <= r_shadow_dp;
                end
                r_pending <= load;
            end else if (load) begin
                r_pending <= 1'b1;
            end

            if ((r_state == c_SLOT_DRIVE) && !blank) begin
                r_seg   <= w_seg_act ^ c_SEG_OFF;
                r_digit <= w_onehot ^ c_DIG_OFF;
            end else begin
                r_seg   <= c_SEG_OFF;
                r_digit <= c_DIG_OFF;
            end
        end
    end

    assign seg_out    = r_seg;
    assign digit_en   = r_digit;
    assign frame_tick = r_frame_tick;
    assign shown_q    = r_disp_data;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_display
//  Description : Self-checking bench for seg_scan_display with 4 digits,
//                4-cycle slots, 1 guard cycle, active-low outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan_display;

    typedef struct {
        logic [7:0] seg;
        logic [3:0] den;
        logic       ft;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  dp;
        logic        blank;
        logic [31:0] exp_shown;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [31:0] data_in;
    logic [3:0]  dp_in;
    logic        blank;
    logic [7:0]  seg_out;
    logic [3:0]  digit_en;
    logic        frame_tick;
    logic [31:0] shown_q;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    vec_t vecs[5];

    seg_scan_display #(
        .DATA_W      (32),
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .GUARD_CYC   (1),
        .ACTIVE_LOW  (1)
    ) u_dut (
        .clock      (clk),
        .reset      (rst_n),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank      (blank),
        .seg_out    (seg_out),
        .digit_en   (digit_en),
        .frame_tick (frame_tick),
        .shown_q    (shown_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Active-high {dp,g..a} for digit k of a displayed value
    function automatic logic [7:0] digit_act(input logic [31:0] disp, input logic [3:0] dp,
                                             input int k);
        logic [3:0] nib;
        logic       lit;
        nib = disp[4*k +: 4];
        lit = 1'b1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        lit = (k == 0) || ((disp[15:0] >> (4 * k)) != 16'h0);
`endif
        return {dp[k], lit ? hex7(nib) : 7'h00};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Expected outputs for the 16 cycles that follow a frame_tick sample
    task automatic push_frame(input logic [31:0] disp, input logic [3:0] dp, input logic blk);
        exp_t e;
        for (int j = 0; j < 16; j++) begin
            if (blk || (j % 4) == 0) begin
                e.seg = 8'hFF;
                e.den = 4'hF;
            end else begin
                e.seg = ~digit_act(disp, dp, j / 4);
                e.den = ~(4'b0001 << (j / 4));
            end
            e.ft = (j == 15);
            sb_q.push_back(e);
        end
    endtask

    task automatic check_window(input string name);
        exp_t e;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL %s[%0d] scoreboard empty", name, j);
            end else begin
                e = sb_q.pop_front();
                if (seg_out !== e.seg || digit_en !== e.den || frame_tick !== e.ft) begin
                    errors++;
                    $display("FAIL %s[%0d] seg/den/tick got %h/%h/%b expected %h/%h/%b",
                             name, j, seg_out, digit_en, frame_tick, e.seg, e.den, e.ft);
                end
            end
        end
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 40);
        if (frame_tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s frame_tick timeout got %b expected 1", name, frame_tick);
        end
    endtask

    initial begin
        int   n;
        logic saw_ab;

        vecs[0] = '{data: 32'h0000_1234, dp: 4'b0000, blank: 1'b0, exp_shown: 32'h0000_1234};
        vecs[1] = '{data: 32'h89AB_CDEF, dp: 4'b0101, blank: 1'b0, exp_shown: 32'h89AB_CDEF};
        vecs[2] = '{data: 32'h0000_0000, dp: 4'b1000, blank: 1'b0, exp_shown: 32'h0000_0000};
        vecs[3] = '{data: 32'hFFFF_5678, dp: 4'b1111, blank: 1'b1, exp_shown: 32'hFFFF_5678};
        vecs[4] = '{data: 32'h0000_0005, dp: 4'b0000, blank: 1'b0, exp_shown: 32'h0000_0005};

        rst_n   = 1'b0;
        load    = 1'b0;
        data_in = '0;
        dp_in   = '0;
        blank   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_seg", 32'(seg_out), 32'hFF);
        chk("rst_den", 32'(digit_en), 32'hF);
        chk("rst_shown", shown_q, 32'h0);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;

        // First wrap arrives after exactly one 16-cycle frame
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 40);
        chk("first_tick_latency", 32'(n), 32'd16);

        // Table: load mid-frame, value appears from the next wrap onwards
        for (int i = 0; i < 5; i++) begin
            blank = vecs[i].blank;
            repeat (2) @(negedge clk);
            data_in = vecs[i].data;
            dp_in   = vecs[i].dp;
            load    = 1'b1;
            @(negedge clk);
            load = 1'b0;
            push_frame(vecs[i].data, vecs[i].dp, vecs[i].blank);
            wait_tick($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_shown", i), shown_q, vecs[i].exp_shown);
            check_window($sformatf("vec%0d_win", i));
        end
        blank = 1'b0;
        dp_in = '0;

        // Two loads in one frame: last one wins, first never displayed
        @(negedge clk);
        data_in = 32'h0000_00AB;
        load    = 1'b1;
        @(negedge clk);
        data_in = 32'h0000_00CD;
        @(negedge clk);
        load   = 1'b0;
        saw_ab = 1'b0;
        n      = 0;
        do begin
            @(negedge clk);
            n++;
            if (shown_q === 32'h0000_00AB) saw_ab = 1'b1;
        end while (frame_tick !== 1'b1 && n < 40);
        chk("lastwins_tick", 32'(frame_tick), 32'h1);
        chk("lastwins_shown", shown_q, 32'h0000_00CD);
        push_frame(32'h0000_00CD, 4'h0, 1'b0);
        check_window("lastwins_win");
        chk("lastwins_no_ab", 32'(saw_ab), 32'h0);

        // Load exactly on the wrap edge: display takes the earlier shadow
        @(negedge clk);
        data_in = 32'h0000_4321;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (13) @(negedge clk);
        data_in = 32'h0000_0F0E;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("wrapload_align", 32'(frame_tick), 32'h1);
        chk("wrapload_old", shown_q, 32'h0000_4321);
        push_frame(32'h0000_4321, 4'h0, 1'b0);
        check_window("wrapload_win");
        chk("wrapload_new", shown_q, 32'h0000_0F0E);

        // Asynchronous reset mid-frame discards the pending value
        @(negedge clk);
        data_in = 32'h0000_7777;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg", 32'(seg_out), 32'hFF);
        chk("arst_den", 32'(digit_en), 32'hF);
        chk("arst_shown", shown_q, 32'h0);
        chk("arst_tick", 32'(frame_tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick("arst");
        chk("arst_pending_lost", shown_q, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
